// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl_if
// Description : Data-memory bus bundle: req/gnt request phase plus
//               rvalid response phase (read data or write ack).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);
  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [XLEN/8-1:0]   bus_wstrb;
  logic [XLEN-1:0]     bus_wdata;
  logic                bus_gnt;
  logic                bus_rvalid;
  logic [XLEN-1:0]     bus_rdata;

  // Access controller side
  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  // Memory / interconnect side
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Load/store sequencer between the MEM stage and the data
//               memory bus. One access outstanding; builds strobes and
//               lane-replicated write data, extends load data, flags
//               misaligned accesses and drops flushed/cancelled accesses.
//               Optional macro DMEM_TIMEOUT_EN adds a response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid_i,
  input  logic                mem_is_load_i,
  input  logic                mem_is_store_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_unsigned_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]     mem_wdata_i,
  input  logic                flush_mem_i,
  input  logic                cancel_instr_mem_i,
  output logic                stall_mem_o,
  output logic                ld_valid_o,
  output logic [XLEN-1:0]     ld_data_o,
  output logic                misalign_exc_o,
  output logic                bus_err_o,
  dmem_access_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                is_load_q, is_load_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     ld_data_q, ld_data_d;
  logic                ld_valid_q, ld_valid_d;
  logic                misalign_q, misalign_d;

  logic                w_start;
  logic                w_kill;
  logic                w_misalign;
  logic                w_in_req;
  logic [2:0]          w_off;
  logic [XLEN/8-1:0]   w_strb_base;
  logic [XLEN/8-1:0]   w_strb;
  logic [XLEN-1:0]     w_wdata_rep;
  logic [XLEN-1:0]     w_rshift;
  logic [XLEN-1:0]     w_ext;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
`else
  logic                unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Nothing may start while reset is asserted, so stall stays low in reset.
  assign w_start = rst_n & (state_q == S_IDLE) & mem_valid_i
                 & (mem_is_load_i | mem_is_store_i)
                 & ~flush_mem_i & ~cancel_instr_mem_i;
  assign w_kill  = flush_mem_i | cancel_instr_mem_i;

  // Natural-alignment check on the incoming address.
  always_comb begin
    w_misalign = 1'b0;
    case (mem_size_i)
      2'd1:    w_misalign = mem_addr_i[0];
      2'd2:    w_misalign = |mem_addr_i[1:0];
      2'd3:    w_misalign = |mem_addr_i[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_off = addr_q[2:0];

  // Per-size strobe base and write-data lane replication.
  always_comb begin
    w_strb_base = '1;
    w_wdata_rep = wdata_q;
    case (size_q)
      2'd0: begin
        w_strb_base = {{(XLEN/8-1){1'b0}}, 1'b1};
        w_wdata_rep = {(XLEN/8){wdata_q[7:0]}};
      end
      2'd1: begin
        w_strb_base = {{(XLEN/8-2){1'b0}}, 2'b11};
        w_wdata_rep = {(XLEN/16){wdata_q[15:0]}};
      end
      2'd2: begin
        w_strb_base = {{(XLEN/8-4){1'b0}}, 4'hF};
        w_wdata_rep = {(XLEN/32){wdata_q[31:0]}};
      end
      default: begin
        w_strb_base = '1;
        w_wdata_rep = wdata_q;
      end
    endcase
  end

  assign w_strb   = w_strb_base << w_off;
  assign w_rshift = bus.bus_rdata >> {w_off, 3'b000};

  // Truncate the shifted read lane and sign/zero-extend it.
  always_comb begin
    w_ext = w_rshift;
    case (size_q)
      2'd0:    w_ext = {{(XLEN-8){~uns_q & w_rshift[7]}},   w_rshift[7:0]};
      2'd1:    w_ext = {{(XLEN-16){~uns_q & w_rshift[15]}}, w_rshift[15:0]};
      2'd2:    w_ext = {{(XLEN-32){~uns_q & w_rshift[31]}}, w_rshift[31:0]};
      default: w_ext = w_rshift;
    endcase
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    is_load_d  = is_load_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    misalign_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          if (w_misalign) begin
            misalign_d = 1'b1;
          end else begin
            addr_d    = mem_addr_i;
            size_d    = mem_size_i;
            uns_d     = mem_unsigned_i;
            is_load_d = mem_is_load_i;
            wdata_d   = mem_wdata_i;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A granted request is already on the bus and must be drained.
        if (w_kill)            state_d = bus.bus_gnt ? S_DRAIN : S_IDLE;
        else if (bus.bus_gnt)  state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.bus_rvalid) begin
          if (w_kill) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (is_load_q) begin
              ld_valid_d = 1'b1;
              ld_data_d  = w_ext;
            end
          end
        end else if (w_kill) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (bus.bus_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef DMEM_TIMEOUT_EN
    if (((state_d == S_RESP) && (state_q != S_RESP)) ||
        ((state_d == S_DRAIN) && (state_q != S_DRAIN))) begin
      cnt_d = '0;
    end else if (((state_q == S_RESP) || (state_q == S_DRAIN)) && !bus.bus_rvalid) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d   = S_IDLE;
        bus_err_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  // State and capture registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      is_load_q  <= 1'b0;
      wdata_q    <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      is_load_q  <= is_load_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  // Response timeout counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err_o = bus_err_q;
`else
  assign bus_err_o = 1'b0;
`endif

  assign w_in_req       = (state_q == S_REQ);
  assign stall_mem_o    = (w_start & ~w_misalign) | w_in_req | (state_q == S_RESP)
                        | ((state_q == S_DRAIN) & mem_valid_i);
  assign ld_valid_o     = ld_valid_q;
  assign ld_data_o      = ld_data_q;
  assign misalign_exc_o = misalign_q;

  // Bus outputs are only driven during the request phase.
  assign bus.bus_req   = w_in_req;
  assign bus.bus_we    = w_in_req & ~is_load_q;
  assign bus.bus_addr  = w_in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.bus_wstrb = w_in_req ? w_strb : '0;
  assign bus.bus_wdata = w_in_req ? w_wdata_rep : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Directed bench for dmem_access_ctrl; load results are
//               checked through an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;
  localparam int XLEN    = 64;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_valid, mem_is_load, mem_is_store, mem_unsigned;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              flush_mem, cancel_instr_mem;
  logic              stall_mem, ld_valid, misalign_exc, bus_err;
  logic [XLEN-1:0]   ld_data;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  dmem_access_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_if ();

  dmem_access_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_valid_i        (mem_valid),
    .mem_is_load_i      (mem_is_load),
    .mem_is_store_i     (mem_is_store),
    .mem_size_i         (mem_size),
    .mem_unsigned_i     (mem_unsigned),
    .mem_addr_i         (mem_addr),
    .mem_wdata_i        (mem_wdata),
    .flush_mem_i        (flush_mem),
    .cancel_instr_mem_i (cancel_instr_mem),
    .stall_mem_o        (stall_mem),
    .ld_valid_o         (ld_valid),
    .ld_data_o          (ld_data),
    .misalign_exc_o     (misalign_exc),
    .bus_err_o          (bus_err),
    .bus                (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    mem_size = 2'd0; mem_unsigned = 1'b0; mem_addr = '0; mem_wdata = '0;
    flush_mem = 1'b0; cancel_instr_mem = 1'b0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
  endtask

  task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [63:0] wd);
    mem_valid = 1'b1; mem_is_load = ld; mem_is_store = ~ld;
    mem_size = sz; mem_unsigned = uns; mem_addr = a; mem_wdata = wd;
  endtask

  // Complete load with immediate grant and response; result goes to the queue.
  task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [63:0] rd, input logic [63:0] exp);
    nxt(); issue(1'b1, sz, uns, a, '0); #1;
    chk1({tag, "_start_stall"}, stall_mem, 1'b1);
    exp_q.push_back(exp);
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    chk({tag, "_addr"}, 64'(bus_if.bus_addr), {32'd0, a[31:3], 3'b000});
    nxt(); bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rd; #1;
    nxt(); idle_in(); #1;
    chk1({tag, "_ld_valid"}, ld_valid, 1'b1);
    nxt(); #1;
    chk1({tag, "_ld_valid_end"}, ld_valid, 1'b0);
  endtask

  // Scoreboard: every ld_valid pulse consumes one expected load result.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      if (exp_q.size() == 0) chk1("ld_spurious", ld_valid, 1'b0);
      else                   chk("ld_data", ld_data, exp_q.pop_front());
    end
  end

  initial begin
    logic [1:0]  mis_sz [3];
    logic [31:0] mis_a  [3];
    mis_sz[0] = 2'd2; mis_a[0] = 32'h8000_0002;
    mis_sz[1] = 2'd1; mis_a[1] = 32'h8000_0001;
    mis_sz[2] = 2'd3; mis_a[2] = 32'h8000_0004;

    idle_in();
    #2;
    chk1("rst_req", bus_if.bus_req, 1'b0);
    chk1("rst_stall", stall_mem, 1'b0);
    chk1("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_ld_data", ld_data, 64'd0);
    chk1("rst_misalign", misalign_exc, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk("rst_wstrb", 64'(bus_if.bus_wstrb), 64'd0);
    #10 rst_n = 1'b1;

    // Load byte, signed, grant after two request cycles
    nxt(); issue(1'b1, 2'd0, 1'b0, 32'h8000_0003, '0); #1;
    chk1("lb_start_stall", stall_mem, 1'b1);
    chk1("lb_start_req", bus_if.bus_req, 1'b0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
    nxt(); #1;
    chk1("lb_req", bus_if.bus_req, 1'b1);
    chk("lb_addr", 64'(bus_if.bus_addr), 64'h8000_0000);
    chk("lb_wstrb", 64'(bus_if.bus_wstrb), 64'h08);
    chk1("lb_we", bus_if.bus_we, 1'b0);
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    chk1("lb_req_hold", bus_if.bus_req, 1'b1);
    chk1("lb_req_stall", stall_mem, 1'b1);
    nxt(); bus_if.bus_gnt = 1'b0; #1;
    chk1("lb_resp_req", bus_if.bus_req, 1'b0);
    chk1("lb_resp_stall", stall_mem, 1'b1);
    nxt(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 64'h0000_0000_8000_0000; #1;
    chk1("lb_rvalid_stall", stall_mem, 1'b1);
    chk1("lb_rvalid_ldv", ld_valid, 1'b0);
    nxt(); idle_in(); #1;
    chk1("lb_done_ldv", ld_valid, 1'b1);
    chk1("lb_done_stall", stall_mem, 1'b0);
    nxt(); #1;
    chk1("lb_after_ldv", ld_valid, 1'b0);

    // Store half at offset 6 with upper store-data bits as noise
    nxt(); issue(1'b0, 2'd1, 1'b0, 32'h8000_0006, 64'hDEAD_BEEF_0000_1234); #1;
    chk1("sh_start_stall", stall_mem, 1'b1);
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    chk1("sh_req", bus_if.bus_req, 1'b1);
    chk1("sh_we", bus_if.bus_we, 1'b1);
    chk("sh_wstrb", 64'(bus_if.bus_wstrb), 64'hC0);
    chk("sh_wdata", bus_if.bus_wdata, 64'h1234_1234_1234_1234);
    chk("sh_addr", 64'(bus_if.bus_addr), 64'h8000_0000);
    nxt(); bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; #1;
    chk1("sh_ack_stall", stall_mem, 1'b1);
    nxt(); idle_in(); #1;
    chk1("sh_done_ldv", ld_valid, 1'b0);
    chk1("sh_done_stall", stall_mem, 1'b0);

    // Misaligned word, half and dword accesses
    for (int i = 0; i < 3; i++) begin
      nxt(); issue(1'b1, mis_sz[i], 1'b0, mis_a[i], '0); #1;
      chk1("mis_stall", stall_mem, 1'b0);
      chk1("mis_req0", bus_if.bus_req, 1'b0);
      nxt(); idle_in(); #1;
      chk1("mis_pulse", misalign_exc, 1'b1);
      chk1("mis_req1", bus_if.bus_req, 1'b0);
      nxt(); #1;
      chk1("mis_pulse_end", misalign_exc, 1'b0);
    end

    // Extraction variants
    run_load("lh", 2'd1, 1'b0, 32'h8000_0002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    run_load("lbu", 2'd0, 1'b1, 32'h8000_0007, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5);
    run_load("ld", 2'd3, 1'b0, 32'h8000_0008, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);

    // Flush in RESP, next load held until the drain completes
    nxt(); issue(1'b1, 2'd3, 1'b0, 32'h8000_0008, '0); #1;
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    nxt(); bus_if.bus_gnt = 1'b0; flush_mem = 1'b1; #1;
    chk1("fl_resp_stall", stall_mem, 1'b1);
    nxt(); flush_mem = 1'b0; issue(1'b1, 2'd2, 1'b1, 32'h8000_0010, '0); #1;
    chk1("fl_drain_stall0", stall_mem, 1'b1);
    chk1("fl_drain_req0", bus_if.bus_req, 1'b0);
    nxt(); #1;
    chk1("fl_drain_stall1", stall_mem, 1'b1);
    nxt(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0; #1;
    chk1("fl_drain_stall2", stall_mem, 1'b1);
    nxt(); bus_if.bus_rvalid = 1'b0; #1;
    chk1("fl_drop_ldv", ld_valid, 1'b0);
    chk1("fl_new_stall", stall_mem, 1'b1);
    chk1("fl_new_req0", bus_if.bus_req, 1'b0);
    exp_q.push_back(64'h0000_0000_F333_4444);
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    chk1("fl_new_req", bus_if.bus_req, 1'b1);
    chk("fl_new_addr", 64'(bus_if.bus_addr), 64'h8000_0010);
    chk("fl_new_wstrb", 64'(bus_if.bus_wstrb), 64'h0F);
    nxt(); bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 64'h1111_2222_F333_4444; #1;
    nxt(); idle_in(); #1;
    chk1("fl_new_ldv", ld_valid, 1'b1);

    // Cancel in REQ without grant
    nxt(); issue(1'b1, 2'd2, 1'b0, 32'h8000_0020, '0); #1;
    nxt(); cancel_instr_mem = 1'b1; #1;
    chk1("cn_req", bus_if.bus_req, 1'b1);
    nxt(); idle_in(); #1;
    chk1("cn_req_drop", bus_if.bus_req, 1'b0);
    chk1("cn_stall", stall_mem, 1'b0);

    // Flush together with rvalid completes silently
    nxt(); issue(1'b1, 2'd2, 1'b0, 32'h8000_0020, '0); #1;
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    nxt(); bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; flush_mem = 1'b1; #1;
    nxt(); idle_in(); #1;
    chk1("fr_ldv", ld_valid, 1'b0);
    chk1("fr_stall", stall_mem, 1'b0);

    // Reset asserted mid-RESP
    nxt(); issue(1'b1, 2'd3, 1'b0, 32'h8000_0030, '0); #1;
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    nxt(); bus_if.bus_gnt = 1'b0; #1;
    chk1("rr_pre_stall", stall_mem, 1'b1);
    rst_n = 1'b0; #1;
    chk1("rr_req", bus_if.bus_req, 1'b0);
    chk1("rr_stall", stall_mem, 1'b0);
    chk1("rr_ldv", ld_valid, 1'b0);
    idle_in();
    nxt(); rst_n = 1'b1; bus_if.bus_rvalid = 1'b1; #1;
    nxt(); bus_if.bus_rvalid = 1'b0; #1;
    chk1("rr_idle_ldv", ld_valid, 1'b0);
    chk1("rr_idle_stall", stall_mem, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // No response: error pulse after TIMEOUT cycles in RESP
    nxt(); issue(1'b1, 2'd3, 1'b0, 32'h8000_0040, '0); #1;
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    nxt(); bus_if.bus_gnt = 1'b0; #1;
    chk1("to_err0", bus_err, 1'b0);
    for (int k = 1; k < TIMEOUT; k++) begin
      nxt(); #1;
      chk1("to_wait_err", bus_err, 1'b0);
      chk1("to_wait_stall", stall_mem, 1'b1);
    end
    nxt(); idle_in(); #1;
    chk1("to_err", bus_err, 1'b1);
    chk1("to_stall", stall_mem, 1'b0);
    chk1("to_ldv", ld_valid, 1'b0);
    nxt(); #1;
    chk1("to_err_end", bus_err, 1'b0);
`else
    // No timeout: RESP waits indefinitely
    nxt(); issue(1'b0, 2'd3, 1'b0, 32'h8000_0040, 64'h0123_4567_89AB_CDEF); #1;
    nxt(); bus_if.bus_gnt = 1'b1; #1;
    nxt(); bus_if.bus_gnt = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      nxt(); #1;
      chk1("nt_err", bus_err, 1'b0);
      chk1("nt_stall", stall_mem, 1'b1);
    end
    bus_if.bus_rvalid = 1'b1; #1;
    nxt(); idle_in(); #1;
    chk1("nt_done_stall", stall_mem, 1'b0);
`endif

    nxt(); nxt(); #1;
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
